// File: rtl/fifo_stream_packetizer.sv
// fifo_stream_packetizer: drains a push/pop FIFO and frames its words into
// packets on a registered valid/ready stream with first/last markers.
// One word is held as lookahead so the packetizer knows whether it is the
// last word of its packet: a packet closes after max_len words, or when the
// FIFO has stayed empty for timeout cycles while a word is held.
module fifo_stream_packetizer #(
  parameter int width   = 8,
  parameter int max_len = 4,
  parameter int timeout = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_read_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_first,
  output logic             out_last
);

  localparam int iw = (max_len > 1) ? $clog2(max_len) : 1;
  localparam int tw = $clog2(timeout + 1);
  localparam logic [iw-1:0] idx_last  = iw'(max_len - 1);
  localparam logic [tw-1:0] timer_max = tw'(timeout);

  logic [width-1:0] hold_data;
  logic             hold_valid;
  logic [iw-1:0]    hold_idx;
  logic [iw-1:0]    idx;
  logic [tw-1:0]    timer;

  logic          out_free;
  logic          at_max;
  logic          timed_out;
  logic          send;
  logic          send_last;
  logic [iw-1:0] pop_idx;

  // Send decision for the held word and the FIFO pop request.
  always_comb begin
    out_free  = ~out_valid | out_ready;
    at_max    = (hold_idx == idx_last);
    timed_out = (timer == timer_max);
    send      = hold_valid & out_free & (at_max | ~fifo_empty | timed_out);
    // When a send happens without reaching max_len, an empty FIFO means the
    // timeout fired, so the word closes the packet.
    send_last = at_max | fifo_empty;
    fifo_pop  = ~rst & ~fifo_empty & (~hold_valid | send);
    // A word popped on the same edge a packet closes starts the next packet.
    pop_idx   = (send & send_last) ? '0 : idx;
  end

  // Lookahead hold register and the packet index of the next popped word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_idx   <= '0;
      idx        <= '0;
    end else begin
      if (fifo_pop) begin
        hold_data  <= fifo_read_data;
        hold_valid <= 1'b1;
        hold_idx   <= pop_idx;
        idx        <= (pop_idx == idx_last) ? '0 : pop_idx + iw'(1);
      end else begin
        if (send) begin
          hold_valid <= 1'b0;
        end
        if (send & send_last) begin
          idx <= '0;
        end
      end
    end
  end

  // Output register: loads on send, frozen while stalled, clears when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (send) begin
      out_valid <= 1'b1;
      out_data  <= hold_data;
      out_first <= (hold_idx == '0);
      out_last  <= send_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Idle timer: counts empty-FIFO cycles while a word is held, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (fifo_pop | ~hold_valid) begin
      timer <= '0;
    end else if (fifo_empty && !timed_out) begin
      timer <= timer + tw'(1);
    end
  end

endmodule

// File: tb/tb_fifo_stream_packetizer.sv
// Bench for fifo_stream_packetizer: queue-based FIFO models feed two
// instances (default parameters, and max_len=1/timeout=1); expected words
// with their framing are queued at push time and a monitor per instance
// pops and compares them on every output transfer.
module tb_fifo_stream_packetizer;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_read_data = 8'h00;
  logic       fifo_pop;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_first;
  logic       out_last;

  logic       fifo_empty2 = 1'b1;
  logic [7:0] fifo_read_data2 = 8'h00;
  logic       fifo_pop2;
  logic       out_valid2;
  logic       out_ready2 = 1'b1;
  logic [7:0] out_data2;
  logic       out_first2;
  logic       out_last2;

  fifo_stream_packetizer #(.width(8), .max_len(4), .timeout(16)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last)
  );

  fifo_stream_packetizer #(.width(8), .max_len(1), .timeout(1)) dut2 (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty2), .fifo_read_data(fifo_read_data2), .fifo_pop(fifo_pop2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_first(out_first2), .out_last(out_last2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] fq[$];
  logic [7:0] fq2[$];
  exp_t       eq[$];
  exp_t       eq2[$];
  int         xfer_log[$];
  int         checks = 0;
  int         errors = 0;
  int         empty_cyc = 0;
  int         n_xfer2 = 0;
  exp_t       e1, e2;
  logic       stall_p = 1'b0;
  logic [9:0] stall_v = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic upd();
    fifo_empty      = (fq.size() == 0);
    fifo_read_data  = fifo_empty ? 8'h00 : fq[0];
    fifo_empty2     = (fq2.size() == 0);
    fifo_read_data2 = fifo_empty2 ? 8'h00 : fq2[0];
  endtask

  task automatic exp_push(input logic [7:0] d, input bit f, input bit l);
    exp_t t;
    t.data = d; t.first = f; t.last = l;
    eq.push_back(t);
  endtask

  task automatic push1(input logic [7:0] d, input bit f, input bit l);
    fq.push_back(d);
    exp_push(d, f, l);
    upd();
  endtask

  // One clock: FIFO pops requested before the edge are applied after it.
  task automatic tick();
    bit p1, p2;
    @(negedge clk);
    p1 = fifo_pop;
    p2 = fifo_pop2;
    @(posedge clk);
    #1;
    if (p1 && fq.size() > 0) begin
      void'(fq.pop_front());
      if (fq.size() == 0) empty_cyc = cyc;
    end
    if (p2 && fq2.size() > 0) void'(fq2.pop_front());
    out_ready2 = 1'($urandom_range(0, 1));
    upd();
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while ((eq.size() > 0 || fq.size() > 0 || out_valid) && n < bound) begin
      tick();
      n++;
    end
    chk({name, "_drain_left"}, eq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    eq.delete();
    fq.delete();
    xfer_log.delete();
    upd();
  endtask

  // Monitor for the default instance: scoreboard compare and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (fifo_empty) chk("pop_while_empty", int'(fifo_pop), 0);
      if (stall_p) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_stable", int'({out_data, out_first, out_last}), int'(stall_v));
      end
      if (out_valid && !out_ready) begin
        stall_p = 1'b1;
        stall_v = {out_data, out_first, out_last};
      end else begin
        stall_p = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data 0x%0h, expected no word", out_data);
        end else begin
          e1 = eq.pop_front();
          chk("data", int'(out_data), int'(e1.data));
          chk("first", int'(out_first), int'(e1.first));
          chk("last", int'(out_last), int'(e1.last));
        end
        xfer_log.push_back(cyc);
      end
    end
  end

  // Monitor for the max_len=1 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_empty2) chk("pop2_while_empty", int'(fifo_pop2), 0);
      if (out_valid2 && out_ready2) begin
        if (eq2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word2: got data 0x%0h, expected no word", out_data2);
        end else begin
          e2 = eq2.pop_front();
          chk("data2", int'(out_data2), int'(e2.data));
          chk("first2", int'(out_first2), int'(e2.first));
          chk("last2", int'(out_last2), int'(e2.last));
        end
        n_xfer2++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int n;
    int k;
    logic [7:0] d;

    // Test 1: preload nine words while in reset, check reset state.
    for (int i = 0; i < 9; i++) begin
      d = 8'(i * 17);
      push1(d, (i % 4) == 0 || i == 8, (i % 4) == 3 || i == 8);
    end
    tick();
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_first", int'(out_first), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_fifo_pop", int'(fifo_pop), 0);
    chk("rst_out_valid2", int'(out_valid2), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    drain("t1", 80);
    chk("t1_count", xfer_log.size(), 9);
    if (xfer_log.size() == 9) begin
      chk("t1_back_to_back", xfer_log[7] - xfer_log[0], 7);
      chk("t1_timeout_latency", xfer_log[8] - empty_cyc, 17);
    end

    // Test 2: two words, second closes the packet by timeout.
    do_reset();
    push1(8'h00, 1, 0);
    push1(8'h11, 0, 1);
    drain("t2", 80);
    chk("t2_count", xfer_log.size(), 2);
    if (xfer_log.size() == 2) chk("t2_timeout_latency", xfer_log[1] - empty_cyc, 17);

    // Test 3: continuous push with out_ready pattern 1,0,0,1.
    do_reset();
    k = 0;
    for (int i = 0; i < 8; i++) begin
      push1(8'($urandom_range(0, 255)), (k % 4) == 0, (k % 4) == 3);
      k++;
    end
    for (int i = 0; i < 32; i++) begin
      push1(8'($urandom_range(0, 255)), (k % 4) == 0, (k % 4) == 3);
      k++;
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    n = 0;
    while (eq.size() > 0 && n < 400) begin
      out_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    out_ready = 1'b1;
    drain("t3", 50);
    chk("t3_count", xfer_log.size(), 40);

    // Test 4: FIFO refilled one cycle before the timer expires.
    do_reset();
    push1(8'h00, 1, 0);
    push1(8'h11, 0, 0);
    n = 0;
    while (fq.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    e = empty_cyc;
    while (cyc < e + 15) tick();
    push1(8'h22, 0, 0);
    push1(8'h33, 0, 1);
    push1(8'h44, 1, 0);
    push1(8'h55, 0, 1);
    drain("t4", 80);
    chk("t4_count", xfer_log.size(), 6);
    if (xfer_log.size() == 6) chk("t4_timeout_latency", xfer_log[5] - empty_cyc, 17);

    // Test 5: reset while a word is stalled on the output.
    do_reset();
    out_ready = 1'b0;
    fq.push_back(8'haa);
    fq.push_back(8'hbb);
    fq.push_back(8'hcc);
    upd();
    repeat (4) tick();
    chk("t5_pre_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("t5_async_valid", int'(out_valid), 0);
    chk("t5_async_pop", int'(fifo_pop), 0);
    tick();
    tick();
    rst = 1'b0;
    eq.delete();
    xfer_log.delete();
    exp_push(8'hcc, 1, 0);
    push1(8'hdd, 0, 0);
    push1(8'hee, 0, 0);
    push1(8'hff, 0, 1);
    out_ready = 1'b1;
    drain("t5", 80);
    chk("t5_count", xfer_log.size(), 4);

    // Test 6: max_len=1, timeout=1, random words and gaps, random ready.
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      fq2.push_back(d);
      e2.data = d; e2.first = 1'b1; e2.last = 1'b1;
      eq2.push_back(e2);
      upd();
      repeat ($urandom_range(0, 3)) tick();
    end
    n = 0;
    while ((eq2.size() > 0 || fq2.size() > 0) && n < 500) begin
      tick();
      n++;
    end
    chk("t6_left", eq2.size(), 0);
    chk("t6_count", n_xfer2, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
